// File: rtl/nxn_matmul_pkg.sv
// ============================================================================
// Module : nxn_matmul_pkg
// Brief  : State encoding, FP constants, element offset helper and the
//          single-precision multiply/add kernels used by fp_mac_step.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package nxn_matmul_pkg;

    localparam int          FP_W    = 32;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_MUL      = 3'd2,
        S_MUL_WAIT = 3'd3,
        S_ADD      = 3'd4,
        S_ADD_WAIT = 3'd5,
        S_STORE    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

    // Bit offset of element [i][j]; element [0][0] sits in the MSBs.
    function automatic int idx(input int i, input int j, input int len);
        return (len * len - 1 - (i * len + j)) * FP_W;
    endfunction

    // Round-to-nearest-even multiply; denormals flush to zero.
    function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
        logic               s;
        logic [47:0]        p;
        logic [24:0]        m;
        logic signed [9:0]  e;
        logic               g, st;
        logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
        s      = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'h00);
        b_zero = (b[30:23] == 8'h00);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) return FP_QNAN;
        if (a_inf || b_inf) return {s, 8'hFF, 23'h0};
        if (a_zero || b_zero) return {s, 31'h0};
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (p[47]) begin
            m  = {1'b0, p[47:24]};
            g  = p[23];
            st = |p[22:0];
            e  = e + 10'sd1;
        end else begin
            m  = {1'b0, p[46:23]};
            g  = p[22];
            st = |p[21:0];
        end
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (e >= 10'sd255) return {s, 8'hFF, 23'h0};
        if (e <= 10'sd0) return {s, 31'h0};
        return {s, e[7:0], m[22:0]};
    endfunction

    // Round-to-nearest-even add with guard/round/sticky; denormals flush to zero.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y;
        logic [7:0]         d8;
        logic [26:0]        mx, my, mask;
        logic [27:0]        s;
        logic [24:0]        m;
        logic signed [9:0]  e;
        logic               g, st;
        if ((a[30:23] == 8'hFF) || (b[30:23] == 8'hFF)) begin
            if ((a[30:23] == 8'hFF) && (b[30:23] == 8'hFF) &&
                ((a[31] != b[31]) || (a[22:0] != 23'h0) || (b[22:0] != 23'h0)))
                return FP_QNAN;
            return (a[30:23] == 8'hFF) ? a : b;
        end
        if (a[30:23] == 8'h00) return (b[30:23] == 8'h00) ? {a[31] & b[31], 31'h0} : b;
        if (b[30:23] == 8'h00) return a;
        if (b[30:0] > a[30:0]) begin
            x = b;
            y = a;
        end else begin
            x = a;
            y = b;
        end
        d8 = x[30:23] - y[30:23];
        mx = {1'b1, x[22:0], 3'b000};
        my = {1'b1, y[22:0], 3'b000};
        if (d8 > 8'd26) begin
            my = 27'd1;
        end else begin
            mask = (27'd1 << d8) - 27'd1;
            st   = |(my & mask);
            my   = (my >> d8) | {26'd0, st};
        end
        e = $signed({2'b00, x[30:23]});
        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
        else                s = {1'b0, mx} - {1'b0, my};
        if (s == 28'd0) return FP_ZERO;
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'sd1;
        end
        for (int n = 0; n < 26; n++) begin
            if (!s[26]) begin
                s = s << 1;
                e = e - 10'sd1;
            end
        end
        m  = {1'b0, s[26:3]};
        g  = s[2];
        st = |s[1:0];
        if (g && (st || m[0])) m = m + 25'd1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 10'sd1;
        end
        if (e >= 10'sd255) return {x[31], 8'hFF, 23'h0};
        if (e <= 10'sd0) return FP_ZERO;
        return {x[31], e[7:0], m[22:0]};
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_mac_step.sv
// ============================================================================
// Module : fp_mac_step
// Brief  : One multiply-accumulate step around a strobed FP multiplier and a
//          load/ready FP adder; owns prod/acc and the k==0 bypass.
//          MATMUL_ACC_EN: k==0 adds C[i][j] instead of bypassing.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fp_mac_step
    import nxn_matmul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_first,
    input  logic        i_mul_start,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
`ifdef MATMUL_ACC_EN
    input  logic [31:0] i_c,
`endif
    input  logic        i_add_start,
    output logic        o_mul_done,
    output logic        o_need_add,
    output logic        o_add_done,
    output logic [31:0] o_acc
);

    logic [31:0] r_mul_a, r_mul_b, r_mul_z, r_prod;
    logic        r_mul_stb, r_mul_zstb;
    logic [31:0] r_add_a, r_add_b, r_sum, r_acc;
    logic        r_add_ld, r_add_rdy;
    logic [31:0] w_add_a;

`ifdef MATMUL_ACC_EN
    assign o_need_add = 1'b1;
    assign w_add_a    = i_first ? i_c : r_acc;
`else
    assign o_need_add = !i_first;
    assign w_add_a    = r_acc;
`endif

    // Output strobes are acknowledged in the same cycle they are seen.
    assign o_mul_done = r_mul_zstb;
    assign o_add_done = r_add_rdy;
    assign o_acc      = r_acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mul_a    <= FP_ZERO;
            r_mul_b    <= FP_ZERO;
            r_mul_z    <= FP_ZERO;
            r_prod     <= FP_ZERO;
            r_mul_stb  <= 1'b0;
            r_mul_zstb <= 1'b0;
            r_add_a    <= FP_ZERO;
            r_add_b    <= FP_ZERO;
            r_sum      <= FP_ZERO;
            r_acc      <= FP_ZERO;
            r_add_ld   <= 1'b0;
            r_add_rdy  <= 1'b0;
        end else begin
            if (i_mul_start) begin
                r_mul_a   <= i_a;
                r_mul_b   <= i_b;
                r_mul_stb <= 1'b1;
            end else if (r_mul_stb) begin
                r_mul_z    <= fp_mul(r_mul_a, r_mul_b);
                r_mul_stb  <= 1'b0;
                r_mul_zstb <= 1'b1;
            end
            if (r_mul_zstb) begin
                r_mul_zstb <= 1'b0;
                r_prod     <= r_mul_z;
                if (!o_need_add) r_acc <= r_mul_z;
            end
            if (i_add_start) begin
                r_add_a  <= w_add_a;
                r_add_b  <= r_prod;
                r_add_ld <= 1'b1;
            end else if (r_add_ld) begin
                r_sum     <= fp_add(r_add_a, r_add_b);
                r_add_ld  <= 1'b0;
                r_add_rdy <= 1'b1;
            end
            if (r_add_rdy) begin
                r_add_rdy <= 1'b0;
                r_acc     <= r_sum;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/nxn_matrix_mult_seq.sv
// ============================================================================
// Module : nxn_matrix_mult_seq
// Brief  : Sequential LENGTH x LENGTH single-precision matrix multiply through
//          one shared MAC step. MATMUL_ACC_EN adds port C: Res = A x B + C.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module nxn_matrix_mult_seq
    import nxn_matmul_pkg::*;
#(
    parameter int FLOATSIZE = 32,
    parameter int LENGTH    = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 load,
    input  logic [LENGTH*LENGTH*FLOATSIZE-1:0]   A,
    input  logic [LENGTH*LENGTH*FLOATSIZE-1:0]   B,
`ifdef MATMUL_ACC_EN
    input  logic [LENGTH*LENGTH*FLOATSIZE-1:0]   C,
`endif
    output logic [LENGTH*LENGTH*FLOATSIZE-1:0]   Res,
    output logic                                 result_ready,
    input  logic                                 result_ack,
    output logic                                 busy
);

    localparam int              IDXW     = (LENGTH > 2) ? $clog2(LENGTH) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(LENGTH - 1);

    state_t                                 r_state, w_state_nxt;
    logic [IDXW-1:0]                        r_i, r_j, r_k;
    logic [FLOATSIZE-1:0]                   w_a [LENGTH][LENGTH];
    logic [FLOATSIZE-1:0]                   w_b [LENGTH][LENGTH];
    logic [FLOATSIZE-1:0]                   r_a [LENGTH][LENGTH];
    logic [FLOATSIZE-1:0]                   r_b [LENGTH][LENGTH];
    logic [FLOATSIZE-1:0]                   r_res_arr [LENGTH][LENGTH];
    logic [LENGTH*LENGTH*FLOATSIZE-1:0]     w_res_pack;
    logic                                   w_mul_start, w_add_start;
    logic                                   w_mul_done, w_need_add, w_add_done;
    logic [FLOATSIZE-1:0]                   w_acc;
    logic                                   w_i_last, w_j_last, w_k_last;
`ifdef MATMUL_ACC_EN
    logic [FLOATSIZE-1:0]                   w_c [LENGTH][LENGTH];
    logic [FLOATSIZE-1:0]                   r_c [LENGTH][LENGTH];
`endif

    for (genvar gi = 0; gi < LENGTH; gi++) begin : g_row
        for (genvar gj = 0; gj < LENGTH; gj++) begin : g_col
            assign w_a[gi][gj] = A[idx(gi, gj, LENGTH) +: FLOATSIZE];
            assign w_b[gi][gj] = B[idx(gi, gj, LENGTH) +: FLOATSIZE];
`ifdef MATMUL_ACC_EN
            assign w_c[gi][gj] = C[idx(gi, gj, LENGTH) +: FLOATSIZE];
`endif
            assign w_res_pack[idx(gi, gj, LENGTH) +: FLOATSIZE] = r_res_arr[gi][gj];
        end
    end

    assign w_i_last = (r_i == IDX_LAST);
    assign w_j_last = (r_j == IDX_LAST);
    assign w_k_last = (r_k == IDX_LAST);
    assign busy     = (r_state != S_IDLE);

    fp_mac_step u_mac (
        .clk         (clk),
        .rst         (reset),
        .i_first     (r_k == '0),
        .i_mul_start (w_mul_start),
        .i_a         (r_a[r_i][r_k]),
        .i_b         (r_b[r_k][r_j]),
`ifdef MATMUL_ACC_EN
        .i_c         (r_c[r_i][r_j]),
`endif
        .i_add_start (w_add_start),
        .o_mul_done  (w_mul_done),
        .o_need_add  (w_need_add),
        .o_add_done  (w_add_done),
        .o_acc       (w_acc)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mul_start = 1'b0;
        w_add_start = 1'b0;
        case (r_state)
            S_IDLE:     if (load) w_state_nxt = S_LOAD;
            S_LOAD:     w_state_nxt = S_MUL;
            S_MUL: begin
                w_mul_start = 1'b1;
                w_state_nxt = S_MUL_WAIT;
            end
            S_MUL_WAIT: if (w_mul_done) w_state_nxt = w_need_add ? S_ADD : S_STORE;
            S_ADD: begin
                w_add_start = 1'b1;
                w_state_nxt = S_ADD_WAIT;
            end
            S_ADD_WAIT: if (w_add_done) w_state_nxt = S_STORE;
            S_STORE:    w_state_nxt = (w_k_last && w_j_last && w_i_last) ? S_DONE : S_MUL;
            // Exit only after result_ready has actually been presented.
            S_DONE:     if (result_ready && result_ack) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            Res          <= {(LENGTH*LENGTH){FP_ZERO}};
            result_ready <= 1'b0;
            r_i          <= '0;
            r_j          <= '0;
            r_k          <= '0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_i <= '0;
                    r_j <= '0;
                    r_k <= '0;
                end
                S_STORE: begin
                    if (!w_k_last) begin
                        r_k <= r_k + IDXW'(1);
                    end else begin
                        r_k <= '0;
                        if (!w_j_last) begin
                            r_j <= r_j + IDXW'(1);
                        end else if (!w_i_last) begin
                            r_j <= '0;
                            r_i <= r_i + IDXW'(1);
                        end
                    end
                end
                S_DONE: begin
                    if (!result_ready) begin
                        Res          <= w_res_pack;
                        result_ready <= 1'b1;
                    end else if (result_ack) begin
                        result_ready <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && (r_state == S_LOAD)) begin
            r_a <= w_a;
            r_b <= w_b;
`ifdef MATMUL_ACC_EN
            r_c <= w_c;
`endif
        end
        if (!reset && (r_state == S_STORE) && w_k_last) r_res_arr[r_i][r_j] <= w_acc;
    end

endmodule

`default_nettype wire

// File: tb/tb_nxn_matrix_mult_seq.sv
// ============================================================================
// Module : tb_nxn_matrix_mult_seq
// Brief  : Directed self-checking bench for nxn_matrix_mult_seq (LENGTH 2 and
//          4 instances); honours MATMUL_ACC_EN for the accumulate variant.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_nxn_matrix_mult_seq;
    import nxn_matmul_pkg::*;

    logic          clk = 1'b0;
    logic          reset;
    logic          load2, ack2, rdy2, busy2;
    logic          load4, ack4, rdy4, busy4;
    logic [127:0]  a2, b2, res2;
    logic [511:0]  a4, b4, res4;
`ifdef MATMUL_ACC_EN
    logic [127:0]  c2;
    logic [511:0]  c4;
`endif
    logic [31:0]   b_el [16];
    logic [31:0]   exp2 [4];
    int            n_vec = 0;
    int            n_err = 0;
    int            n_done4 = 0;
    int            done_base;
    logic          rdy4_q = 1'b0;
    bit            found;

    always #5 clk = ~clk;

    nxn_matrix_mult_seq #(.FLOATSIZE(32), .LENGTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .load(load2), .A(a2), .B(b2),
`ifdef MATMUL_ACC_EN
        .C(c2),
`endif
        .Res(res2), .result_ready(rdy2), .result_ack(ack2), .busy(busy2)
    );

    nxn_matrix_mult_seq #(.FLOATSIZE(32), .LENGTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .load(load4), .A(a4), .B(b4),
`ifdef MATMUL_ACC_EN
        .C(c4),
`endif
        .Res(res4), .result_ready(rdy4), .result_ack(ack4), .busy(busy4)
    );

    always @(posedge clk) begin
        if (rdy4 && !rdy4_q) n_done4 <= n_done4 + 1;
        rdy4_q <= rdy4;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy(input bit sel4, input string tag);
        int n;
        n = 0;
        while (((sel4 ? rdy4 : rdy2) !== 1'b1) && (n < 4000)) begin
            tick();
            n++;
        end
        check_val(tag, 32'(sel4 ? rdy4 : rdy2), 32'd1);
    endtask

    task automatic set_b4(input logic [31:0] base, input logic [31:0] step);
        for (int n = 0; n < 16; n++) begin
            b_el[n] = base + 32'(n) * step;
            b4[(15 - n) * 32 +: 32] = b_el[n];
        end
    endtask

    task automatic check_res4_eq_b(input string tag);
        for (int n = 0; n < 16; n++)
            check_val($sformatf("%s[%0d]", tag, n), res4[(15 - n) * 32 +: 32], b_el[n]);
    endtask

    task automatic pulse_load4();
        load4 = 1'b1;
        tick();
        load4 = 1'b0;
    endtask

    task automatic ack_dut4(input string tag);
        ack4 = 1'b1;
        tick();
        ack4 = 1'b0;
        check_val({tag, "_rdy_drop"}, 32'(rdy4), 32'd0);
        check_val({tag, "_busy_drop"}, 32'(busy4), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        load2 = 1'b0; ack2 = 1'b0; a2 = '0; b2 = '0;
        load4 = 1'b0; ack4 = 1'b0; a4 = '0; b4 = '0;
`ifdef MATMUL_ACC_EN
        c2 = {4{32'h3F80_0000}};
        c4 = '0;
`endif
        repeat (3) tick();
        check_val("rst_rdy2", 32'(rdy2), 32'd0);
        check_val("rst_busy2", 32'(busy2), 32'd0);
        check_val("rst_res2_nz", 32'(res2 != '0), 32'd0);
        check_val("rst_rdy4", 32'(rdy4), 32'd0);
        check_val("rst_busy4", 32'(busy4), 32'd0);
        reset = 1'b0;
        tick();

        // 2x2 integer product
        a2 = {32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 32'h4080_0000};
        b2 = {32'h40A0_0000, 32'h40C0_0000, 32'h40E0_0000, 32'h4100_0000};
`ifdef MATMUL_ACC_EN
        exp2 = '{32'h41A0_0000, 32'h41B8_0000, 32'h4230_0000, 32'h424C_0000};
`else
        exp2 = '{32'h4198_0000, 32'h41B0_0000, 32'h422C_0000, 32'h4248_0000};
`endif
        load2 = 1'b1;
        tick();
        load2 = 1'b0;
        check_val("s1_busy", 32'(busy2), 32'd1);
        wait_rdy(1'b0, "s1_ready");
        for (int n = 0; n < 4; n++)
            check_val($sformatf("s1_res[%0d]", n), res2[(3 - n) * 32 +: 32], exp2[n]);
        ack2 = 1'b1;
        tick();
        ack2 = 1'b0;
        check_val("s1_rdy_drop", 32'(rdy2), 32'd0);
        check_val("s1_busy_drop", 32'(busy2), 32'd0);

        // 4x4 identity x B, ready held without ack
        for (int n = 0; n < 16; n++)
            a4[(15 - n) * 32 +: 32] = ((n / 4) == (n % 4)) ? 32'h3F80_0000 : 32'h0;
        set_b4(32'h3F80_0000, 32'h0012_3457);
        pulse_load4();
        wait_rdy(1'b1, "s2_ready");
        check_res4_eq_b("s2_res");
        for (int n = 0; n < 5; n++) begin
            tick();
            check_val($sformatf("s2_hold[%0d]", n), 32'(rdy4), 32'd1);
        end
        ack_dut4("s2");

        // Abort with reset in MUL_WAIT of element [1][2]; Res must clear
        set_b4(32'h4100_0000, 32'h0003_1F29);
        pulse_load4();
        found = 1'b0;
        for (int n = 0; n < 4000 && !found; n++) begin
            if (u_dut4.r_state == S_MUL_WAIT && u_dut4.r_i == 2'd1 && u_dut4.r_j == 2'd2)
                found = 1'b1;
            else
                tick();
        end
        check_val("s4_reach_mul_wait_1_2", 32'(found), 32'd1);
        check_val("s4_res_kept", res4[15 * 32 +: 32], 32'h3F80_0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("s4_rdy", 32'(rdy4), 32'd0);
        check_val("s4_busy", 32'(busy4), 32'd0);
        check_val("s4_res_nz", 32'(res4 != '0), 32'd0);
        tick();
        pulse_load4();
        wait_rdy(1'b1, "s4_ready");
        check_res4_eq_b("s4_res");
        ack_dut4("s4");

        // Zero A; load pulses while busy must not start another run
        a4 = '0;
        set_b4(32'h3F00_0000, 32'h0021_0F0F);
        done_base = n_done4;
        pulse_load4();
        repeat (20) begin
            load4 = 1'b1;
            tick();
        end
        load4 = 1'b0;
        wait_rdy(1'b1, "s3_ready");
        for (int n = 0; n < 16; n++)
            check_val($sformatf("s3_res[%0d]", n), res4[(15 - n) * 32 +: 32], 32'h0);
        ack_dut4("s3");
        repeat (20) tick();
        check_val("s3_done_count", 32'(n_done4 - done_base), 32'd1);
        check_val("s3_idle_busy", 32'(busy4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/nxn_matrix_mult_seq.md
Name: nxn_matrix_mult_seq

Overview:
- Parametrised successor to the 2x2 floating-point matrix multiplier: computes Res = A x B for LENGTH x LENGTH single-precision matrices.
- Uses one shared FP multiplier and one FP adder, time-multiplexed through an (i, j, k) loop nest instead of one unit per product.
- Sits between the matrix load logic and downstream consumers.
- Adds a proper result_ack handshake, busy indication and abort-on-reset.

Parameters:
- FLOATSIZE, 32: element width in bits. Fixed at IEEE-754 single precision; other values are illegal.
- LENGTH, 4: matrix dimension N, legal range 2..16. IDXW = max(1, clog2(LENGTH)).

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high reset.
- load, input, 1: start request, sampled only in IDLE.
- A, input, LENGTH*LENGTH*FLOATSIZE: left operand, row-major, element [0][0] in the MSBs. Element [i][j] occupies bits starting at ((LENGTH*LENGTH-1-(i*LENGTH+j))*FLOATSIZE).
- B, input, LENGTH*LENGTH*FLOATSIZE: right operand, same packing as A.
- Res, output, LENGTH*LENGTH*FLOATSIZE: product matrix, same packing as A.
- result_ready, output, 1: Res valid; held until acknowledged.
- result_ack, input, 1: consumer acknowledge of Res.
- busy, output, 1: high in every state except IDLE.

Behaviour:
- Reset: while reset=1 at a clk edge:
  - state <= IDLE; Res <= 0; result_ready <= 0; busy <= 0; i, j, k <= 0.
  - Internal FP units are held in reset.
  - Takes effect in any state and aborts an in-progress computation with no partial Res update.
- FSM states: IDLE, LOAD, MUL, MUL_WAIT, ADD, ADD_WAIT, STORE, DONE.
- IDLE:
  - load=1 -> LOAD. Otherwise stay.
  - load is ignored in all other states.
- LOAD (1 cycle):
  - Capture A and B into internal register arrays.
  - Clear i, j, k, then go to MUL.
  - Inputs may change after the LOAD cycle.
- MUL: present A_reg[i][k] and B_reg[k][j] to the multiplier with both strobes high -> MUL_WAIT.
- MUL_WAIT:
  - Wait for the multiplier output strobe, then latch the product into prod and pulse the multiplier output ack.
  - If k==0: acc <= prod -> STORE. The add is skipped, so 0.0+x signed-zero effects cannot occur.
  - Else -> ADD.
- ADD: present acc and prod to the adder with load=1 -> ADD_WAIT.
- ADD_WAIT: wait for adder result_ready, then acc <= sum and pulse adder result_ack -> STORE.
- STORE: loop advance and result write.
  - If k < LENGTH-1: k++ -> MUL.
  - Else: write acc into Res_reg[i][j] and clear k.
    - If j < LENGTH-1: j++ -> MUL.
    - Else if i < LENGTH-1: clear j, i++ -> MUL.
    - Else -> DONE.
- DONE:
  - Res <= Res_reg on entry; result_ready=1.
  - Hold until result_ack=1, then result_ready <= 0 -> IDLE.
  - Res keeps its value until the next DONE entry or reset.
  - load together with result_ack in DONE: ack is honoured, load is ignored; the consumer re-asserts load in IDLE.
- Order and latency:
  - Products are accumulated strictly in k order 0..LENGTH-1, so results are bit-reproducible.
  - Latency is LENGTH^3 multiplies plus LENGTH^2*(LENGTH-1) adds plus handshake overhead; it is data-dependent and consumers use result_ready only.
- Arithmetic: NaN, Inf and denormal handling is whatever the FP units produce; no extra checking.

Optional Feature:
- Macro: MATMUL_ACC_EN.
- Defined:
  - Adds input port C (LENGTH*LENGTH*FLOATSIZE, same packing), captured in LOAD.
  - Computes Res = A x B + C: at k==0, MUL_WAIT goes to ADD with operands C_reg[i][j] and prod instead of the direct copy.
- Undefined: no C port; behaviour exactly as above.

Decomposition:
- Package nxn_matmul_pkg holds:
  - state encoding constants;
  - the FP zero constant;
  - the element offset function idx(i, j, LENGTH) returning the bit offset of an element.
- One natural sub-module: fp_mac_step. It wraps single_multiplier plus adder and provides start/done pulses and the k==0 bypass, keeping the FSM free of FP handshake details.

Test Plan:
- LENGTH=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], load 1 cycle -> after result_ready, Res = {0x41980000, 0x41B00000, 0x422C0000, 0x42480000} (19, 22, 43, 50).
- LENGTH=4, A=identity (0x3F800000 diagonal), B=random -> Res == B bit-exact; result_ready held for 5 cycles without ack; ack drops it next cycle and busy=0.
- LENGTH=4, A=0, B=random -> Res all 0x00000000. Drive load while busy -> ignored, exactly one DONE.
- Assert reset during MUL_WAIT of element [1][2] -> next cycle result_ready=0, busy=0, Res=0. A fresh load then produces correct results.
- MATMUL_ACC_EN, LENGTH=2, operands from the first scenario, C all 0x3F800000 -> Res = {0x41A00000, 0x41B80000, 0x42300000, 0x424C0000} (20, 23, 44, 51).
